my_seq_setlessthan: RTL and testbench

Sequential, parametrised set-less-than unit for the ALU datapath. It compares two WIDTH-bit operands in signed or unsigned mode, DIGIT bits per clock, starting at the most significant digit. The comparison stops early as soon as a digit differs. A start/busy/done handshake connects it to the ALU control unit, which uses it for SLT/SLTU-class instructions, and the result is presented both as a flag and as a zero-extended WIDTH-bit word.

---
 rtl/my_seq_setlessthan.sv | 116 +++++++++++
 tb/tb_my_seq_setlessthan.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/my_seq_setlessthan.sv
// Sequential set-less-than: compares two WIDTH-bit operands DIGIT bits per clock,
// most significant digit first, stopping at the first differing digit. Signed mode
// is handled by flipping both MSBs on capture, so the digit loop is always unsigned.
module my_seq_setlessthan #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             setres,
  output logic             eq,
  output logic [WIDTH-1:0] Res
);

  localparam int unsigned N      = WIDTH / DIGIT;
  localparam int unsigned IdxW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              setres_q, setres_d;
  logic              eq_q, eq_d;

  logic [WIDTH-1:0]  bias;
  logic [DIGIT-1:0]  a_dig;
  logic [DIGIT-1:0]  b_dig;

  // MSB flip maps two's-complement order onto unsigned order.
  assign bias = {signed_mode, {(WIDTH-1){1'b0}}};

  // Select the digit currently under comparison.
  always_comb begin
    a_dig = a_q[int'(idx_q) * DIGIT +: DIGIT];
    b_dig = b_q[int'(idx_q) * DIGIT +: DIGIT];
  end

  // Next-state logic: capture on accepted start, walk digits, one-cycle done.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    setres_d = setres_q;
    eq_d     = eq_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = A ^ bias;
          b_d     = B ^ bias;
          idx_d   = IdxTop;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (a_dig != b_dig) begin
          setres_d = (a_dig < b_dig);
          eq_d     = 1'b0;
          state_d  = StDone;
        end else if (idx_q == '0) begin
          setres_d = 1'b0;
          eq_d     = 1'b1;
          state_d  = StDone;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      setres_q <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      setres_q <= setres_d;
      eq_q     <= eq_d;
    end
  end

  // Outputs are pure functions of registered state.
  always_comb begin
    busy   = (state_q == StRun);
    done   = (state_q == StDone);
    setres = setres_q;
    eq     = eq_q;
    Res    = {{(WIDTH-1){1'b0}}, setres_q};
  end

endmodule

// File: tb/tb_my_seq_setlessthan.sv
// Directed bench for my_seq_setlessthan with a cycle-level reference model.
module tb_my_seq_setlessthan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] A, B;
  logic        signed_mode;
  logic        busy, done, setres, eq;
  logic [31:0] Res;

  int n_pass  = 0;
  int n_total = 0;
  logic check_en = 1'b0;

  my_seq_setlessthan #(.WIDTH(32), .DIGIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .signed_mode(signed_mode),
    .busy       (busy),
    .done       (done),
    .setres     (setres),
    .eq         (eq),
    .Res        (Res)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Digits examined: stop at the most significant differing digit, else all 8.
  function automatic int digits_examined(input logic [31:0] a, input logic [31:0] b);
    for (int i = 7; i >= 0; i--) begin
      if (((a >> (4 * i)) & 32'hF) != ((b >> (4 * i)) & 32'hF)) return 8 - i;
    end
    return 8;
  endfunction

  function automatic logic is_less(input logic [31:0] a, input logic [31:0] b, input logic sm);
    if (sm) return ($signed(a) < $signed(b));
    return (a < b);
  endfunction

  // Reference model: accepted op finishes K edges later, results land with done.
  logic m_busy, m_done, m_res, m_eq, p_res, p_eq;
  int   m_left;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_res <= 1'b0; m_eq <= 1'b0;
      p_res  <= 1'b0; p_eq   <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_res <= p_res; m_eq <= p_eq;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= digits_examined(A, B);
        p_res  <= is_less(A, B, signed_mode);
        p_eq   <= (A == B);
      end
    end
  end

  // Compare DUT against model every cycle.
  always @(negedge clk) begin
    if (check_en && rst_n) begin
      check("model busy",   {31'b0, busy},   {31'b0, m_busy});
      check("model done",   {31'b0, done},   {31'b0, m_done});
      check("model setres", {31'b0, setres}, {31'b0, m_res});
      check("model eq",     {31'b0, eq},     {31'b0, m_eq});
      check("model Res",    Res,             {31'b0, m_res});
    end
  end

  // One op from idle; latency counts edges from the accepting edge to the done edge.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sm, input int exp_lat, input logic exp_res,
                        input logic exp_eq);
    int lat;
    @(negedge clk);
    A = a; B = b; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " setres"}, {31'b0, setres}, {31'b0, exp_res});
    check({name, " eq"}, {31'b0, eq}, {31'b0, exp_eq});
    check({name, " Res"}, Res, {31'b0, exp_res});
    @(negedge clk);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset setres", {31'b0, setres}, 32'd0);
    check("reset Res", Res, 32'd0);

    run_op("6<8 u", 32'h6, 32'h8, 1'b0, 9, 1'b1, 1'b0);
    run_op("1<0 u", 32'h1, 32'h0, 1'b0, 9, 1'b0, 1'b0);
    run_op("msb u", 32'h8000_0000, 32'h1, 1'b0, 2, 1'b0, 1'b0);
    run_op("msb s", 32'h8000_0000, 32'h1, 1'b1, 2, 1'b1, 1'b0);
    run_op("min<max s", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 2, 1'b1, 1'b0);
    run_op("equal s", 32'h1234_5678, 32'h1234_5678, 1'b1, 9, 1'b0, 1'b1);

    // Start while busy must be ignored.
    @(negedge clk);
    A = 32'hFFFF_FFFF; B = 32'h0000_000F; signed_mode = 1'b1; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    A = 32'h0; B = 32'h1; signed_mode = 1'b0; start = 1'b1;
    check("ignored busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    lat++;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("ignored latency", lat, 2);
    check("ignored setres", {31'b0, setres}, 32'd1);
    @(negedge clk);
    check("ignored back idle", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-run.
    @(negedge clk);
    A = 32'h1234_5678; B = 32'h1234_5678; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", {31'b0, busy}, 32'd0);
    check("arst done", {31'b0, done}, 32'd0);
    check("arst setres", {31'b0, setres}, 32'd0);
    check("arst eq", {31'b0, eq}, 32'd0);
    check("arst Res", Res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post-reset 6<8", 32'h6, 32'h8, 1'b0, 9, 1'b1, 1'b0);

    // Back-to-back: second start lands in the done cycle of the first.
    @(negedge clk);
    A = 32'd5; B = 32'd3; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("b2b first latency", lat, 9);
    check("b2b first setres", {31'b0, setres}, 32'd0);
    A = 32'd3; B = 32'd5; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    check("b2b busy no gap", {31'b0, busy}, 32'd1);
    while (!done && lat < 40) begin
      check("b2b setres held", {31'b0, setres}, 32'd0);
      @(posedge clk); lat++; @(negedge clk);
    end
    check("b2b second latency", lat, 9);
    check("b2b second setres", {31'b0, setres}, 32'd1);
    check("b2b second Res", Res, 32'd1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
